// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: synchronise, debounce, and derive
// registered level / press / release / long-press / auto-repeat strobes.
// Each channel is fully independent; only any_press combines them.
module button_conditioner #(
    parameter int                 N_BTN         = 4,
    parameter logic               PRESS_LEVEL   = 1'b1,
    parameter int                 DB_CYCLES     = 250000,
    parameter int                 LONG_CYCLES   = 12500000,
    parameter int                 REPEAT_CYCLES = 2500000,
    parameter logic [N_BTN-1:0]   REPEAT_MASK   = {N_BTN{1'b1}}
) (
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    input  logic [N_BTN-1:0]  btn_in,
    output logic [N_BTN-1:0]  btn_level,
    output logic [N_BTN-1:0]  btn_press,
    output logic [N_BTN-1:0]  btn_release,
    output logic [N_BTN-1:0]  btn_long,
    output logic [N_BTN-1:0]  btn_repeat,
    output logic              any_press
);

    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HCNT_W   = $clog2(HOLD_MAX);
    localparam int DCNT_W   = $clog2(DB_CYCLES);

    localparam logic [DCNT_W-1:0] DB_LAST     = DCNT_W'(DB_CYCLES - 1);
    localparam logic [HCNT_W-1:0] LONG_LAST   = HCNT_W'(LONG_CYCLES - 1);
    localparam logic [HCNT_W-1:0] REPEAT_LAST = HCNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LONG = 2'd1,
        ST_REPEAT    = 2'd2
    } hold_state_e;

    // Next-cycle strobe values gathered from all channels, registered below.
    logic [N_BTN-1:0] w_press_nxt;
    logic [N_BTN-1:0] w_release_nxt;
    logic [N_BTN-1:0] w_long_nxt;
    logic [N_BTN-1:0] w_repeat_nxt;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic               r_sync1;
        logic               r_sync2;
        logic               r_stable;
        logic [DCNT_W-1:0]  r_dcnt;
        logic               w_accept;
        logic               w_rise;
        logic               w_fall;
        hold_state_e        r_state;
        hold_state_e        w_state_nxt;
        logic [HCNT_W-1:0]  r_hcnt;
        logic [HCNT_W-1:0]  w_hcnt_nxt;
        logic               w_press;
        logic               w_release;
        logic               w_long;
        logic               w_repeat;

        // Two-flop synchroniser on the polarity-normalised pin.
        always_ff @(posedge vga_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                // NOTE: sequential state uses non-blocking assignment so every
                // flop samples pre-edge values regardless of statement order.
                r_sync1 <= (btn_in[i] == PRESS_LEVEL);
                r_sync2 <= r_sync1;
            end
        end

        // A new level is accepted on the DB_CYCLES-th consecutive disagreeing
        // sample; the strobes are generated from the same condition so they
        // line up with the level change.
        assign w_accept = (r_sync2 != r_stable) && (r_dcnt == DB_LAST);
        assign w_rise   = w_accept &  r_sync2;
        assign w_fall   = w_accept & ~r_sync2;

        // Debounce: any agreeing sample restarts the disagreement count.
        always_ff @(posedge vga_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_stable <= 1'b0;
                r_dcnt   <= '0;
            end else if (r_sync2 == r_stable) begin
                r_dcnt   <= '0;
            end else if (r_dcnt == DB_LAST) begin
                r_stable <= r_sync2;
                r_dcnt   <= '0;
            end else begin
                r_dcnt   <= r_dcnt + DCNT_W'(1);
            end
        end

        // Hold FSM state and hold counter registers.
        always_ff @(posedge vga_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_state <= ST_IDLE;
                r_hcnt  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_hcnt  <= w_hcnt_nxt;
            end
        end

        // Hold FSM next state and strobes; a release beats long/repeat.
        always_comb begin
            // NOTE: every combinational output gets a default first so no
            // path leaves it unassigned and no latch is inferred.
            w_state_nxt = r_state;
            w_hcnt_nxt  = r_hcnt;
            w_press     = 1'b0;
            w_release   = 1'b0;
            w_long      = 1'b0;
            w_repeat    = 1'b0;
            if (w_fall) begin
                w_release   = 1'b1;
                w_hcnt_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            w_press     = 1'b1;
                            w_repeat    = 1'b1;
                            w_hcnt_nxt  = '0;
                            w_state_nxt = ST_WAIT_LONG;
                        end
                    end
                    ST_WAIT_LONG: begin
                        if (r_hcnt == LONG_LAST) begin
                            w_long      = 1'b1;
                            w_repeat    = REPEAT_MASK[i];
                            w_hcnt_nxt  = '0;
                            w_state_nxt = ST_REPEAT;
                        end else begin
                            w_hcnt_nxt  = r_hcnt + HCNT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (r_hcnt == REPEAT_LAST) begin
                            w_repeat    = REPEAT_MASK[i];
                            w_hcnt_nxt  = '0;
                        end else begin
                            w_hcnt_nxt  = r_hcnt + HCNT_W'(1);
                        end
                    end
                    default: begin
                        w_hcnt_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end

        assign btn_level[i]     = r_stable;
        assign w_press_nxt[i]   = w_press;
        assign w_release_nxt[i] = w_release;
        assign w_long_nxt[i]    = w_long;
        assign w_repeat_nxt[i]  = w_repeat;
    end

    // Output strobe registers for all channels.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            btn_press   <= '0;
            btn_release <= '0;
            btn_long    <= '0;
            btn_repeat  <= '0;
            any_press   <= 1'b0;
        end else begin
            btn_press   <= w_press_nxt;
            btn_release <= w_release_nxt;
            btn_long    <= w_long_nxt;
            btn_repeat  <= w_repeat_nxt;
            any_press   <= |w_press_nxt;
        end
    end

endmodule
